fifo_read_ctrl: RTL and testbench

//  Read-domain half of the async FIFO; the counterpart of the write-side control logic.

---
 rtl/fifo_read_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fifo_read_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl
//   Read-domain half of an asynchronous FIFO. Brings the write-side Gray
//   pointer into rclk through a flop chain, owns the binary read pointer, and
//   drives the dual-port memory read address. Produces registered read data,
//   empty / almost-empty / underflow / level status, and the registered Gray
//   read pointer handed back to the write domain.
//
//   Optional feature (build macro FIFO_RD_COUNT_EN):
//     defined   -> fifo_read_count counts accepted reads, modulo 2**(ADDR_W+1)
//     undefined -> fifo_read_count is tied to 0 and no counter flops exist
//
// Parameters
//   DATA_W       read data width
//   ADDR_W       memory address width, DEPTH = 2**ADDR_W
//   SYNC_STAGES  synchronizer flop stages for wptr_gray (>= 2)
//
// Ports
//   rclk             in   read clock
//   hw_rst_n         in   asynchronous active-low reset
//   sw_rst           in   synchronous active-high soft reset
//   read_enable      in   read request
//   aempty_value     in   almost-empty threshold in entries
//   wptr_gray        in   write pointer, Gray coded, write clock domain
//   mem_rdata        in   asynchronous memory read data at raddr
//   raddr            out  memory read address
//   rptr_gray        out  registered Gray read pointer to write domain
//   rdata            out  registered read data
//   rd_valid         out  rdata valid strobe
//   rempty           out  FIFO empty
//   rd_almost_empty  out  level <= aempty_value
//   underflow        out  read requested while empty (1-cycle pulse)
//   rd_level         out  entries available, 0..DEPTH
//   fifo_read_count  out  cumulative accepted reads
// -----------------------------------------------------------------------------
module fifo_read_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic              rclk,
  input  logic              hw_rst_n,
  input  logic              sw_rst,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] aempty_value,
  input  logic [ADDR_W:0]   wptr_gray,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W:0]   rptr_gray,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_valid,
  output logic              rempty,
  output logic              rd_almost_empty,
  output logic              underflow,
  output logic [ADDR_W:0]   rd_level,
  output logic [ADDR_W:0]   fifo_read_count
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_W:0] wq_sync [SYNC_STAGES];
  logic [ADDR_W:0] wq_gray;
  logic [ADDR_W:0] wq_bin;
  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] rbin_next;
  logic [ADDR_W:0] rgray_next;
  logic [ADDR_W:0] rd_level_next;
  logic            rd_ok;

  // Write pointer crosses into rclk; only one Gray bit changes per write, so
  // any stage sampled mid-transition still holds an old or new valid pointer.
  always_ff @(posedge rclk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        wq_sync[i] <= '0;
      end
    end else begin
      wq_sync[0] <= wptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        wq_sync[i] <= wq_sync[i-1];
      end
    end
  end

  assign wq_gray = wq_sync[SYNC_STAGES-1];
  assign wq_bin  = gray2bin(wq_gray);

  // Status is computed from the post-read pointer so the read that takes the
  // last entry raises rempty on the same edge, blocking the next request.
  always_comb begin
    rd_ok         = read_enable & ~rempty & ~sw_rst;
    rbin_next     = rd_ok ? rbin + PTR_ONE : rbin;
    rgray_next    = bin2gray(rbin_next);
    rd_level_next = wq_bin - rbin_next;
  end

  always_ff @(posedge rclk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      rbin            <= '0;
      rptr_gray       <= '0;
      rdata           <= '0;
      rd_valid        <= 1'b0;
      rempty          <= 1'b1;
      rd_almost_empty <= 1'b1;
      underflow       <= 1'b0;
      rd_level        <= '0;
    end else if (sw_rst) begin
      rbin            <= '0;
      rptr_gray       <= '0;
      rdata           <= '0;
      rd_valid        <= 1'b0;
      rempty          <= 1'b1;
      rd_almost_empty <= 1'b1;
      underflow       <= 1'b0;
      rd_level        <= '0;
    end else begin
      rbin            <= rbin_next;
      rptr_gray       <= rgray_next;
      rd_valid        <= rd_ok;
      if (rd_ok) begin
        rdata <= mem_rdata;
      end
      rempty          <= (rgray_next == wq_gray);
      rd_almost_empty <= (rd_level_next <= {1'b0, aempty_value});
      underflow       <= read_enable & rempty;
      rd_level        <= rd_level_next;
    end
  end

  assign raddr = rbin[ADDR_W-1:0];

`ifdef FIFO_RD_COUNT_EN
  logic [ADDR_W:0] rd_count;

  always_ff @(posedge rclk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      rd_count <= '0;
    end else if (sw_rst) begin
      rd_count <= '0;
    end else if (rd_ok) begin
      rd_count <= rd_count + PTR_ONE;
    end
  end

  assign fifo_read_count = rd_count;
`else
  assign fifo_read_count = '0;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_ctrl
//   Directed bench for fifo_read_ctrl. The bench plays the write side by
//   stepping a binary write pointer and presenting its Gray code, and models
//   the memory as a fixed function of raddr so every read has a known value.
// -----------------------------------------------------------------------------
module tb_fifo_read_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

`ifdef FIFO_RD_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              rclk = 1'b0;
  logic              hw_rst_n;
  logic              sw_rst;
  logic              read_enable;
  logic [ADDR_W-1:0] aempty_value;
  logic [ADDR_W:0]   wptr_gray;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W:0]   rptr_gray;
  logic [DATA_W-1:0] rdata;
  logic              rd_valid;
  logic              rempty;
  logic              rd_almost_empty;
  logic              underflow;
  logic [ADDR_W:0]   rd_level;
  logic [ADDR_W:0]   fifo_read_count;

  logic [ADDR_W:0]   wbin;
  logic [ADDR_W:0]   rd_idx;
  int                n_tests = 0;
  int                n_fail  = 0;

  always #5 rclk = ~rclk;

  assign wptr_gray = wbin ^ (wbin >> 1);
  assign mem_rdata = 32'hC0DE_0000 | {27'd0, raddr};

  fifo_read_ctrl #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .SYNC_STAGES(2)
  ) dut (
    .rclk           (rclk),
    .hw_rst_n       (hw_rst_n),
    .sw_rst         (sw_rst),
    .read_enable    (read_enable),
    .aempty_value   (aempty_value),
    .wptr_gray      (wptr_gray),
    .mem_rdata      (mem_rdata),
    .raddr          (raddr),
    .rptr_gray      (rptr_gray),
    .rdata          (rdata),
    .rd_valid       (rd_valid),
    .rempty         (rempty),
    .rd_almost_empty(rd_almost_empty),
    .underflow      (underflow),
    .rd_level       (rd_level),
    .fifo_read_count(fifo_read_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [ADDR_W:0] to_gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] exp_word(input logic [ADDR_W:0] idx);
    return 32'hC0DE_0000 | {27'd0, idx[ADDR_W-1:0]};
  endfunction

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      wbin = wbin + 6'd1;
      @(negedge rclk);
    end
  endtask

  task automatic wait_level(input int lvl);
    int k;
    k = 0;
    while (rd_level !== lvl[ADDR_W:0] && k < 12) begin
      @(negedge rclk);
      k++;
    end
    check_eq("wait_level", rd_level, lvl);
  endtask

  task automatic pull(input int n);
    for (int i = 0; i < n; i++) begin
      read_enable = 1'b1;
      @(negedge rclk);
      check_eq("pull_valid", rd_valid, 1);
      check_eq("pull_data", rdata, exp_word(rd_idx));
      rd_idx = rd_idx + 6'd1;
    end
    read_enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1);
  end

  initial begin
    hw_rst_n     = 1'b0;
    sw_rst       = 1'b0;
    read_enable  = 1'b1;
    aempty_value = 5'd4;
    wbin         = '0;
    rd_idx       = '0;

    // 1: reset with read_enable held high
    repeat (2) @(negedge rclk);
    check_eq("rst_rempty", rempty, 1);
    check_eq("rst_aempty", rd_almost_empty, 1);
    check_eq("rst_level", rd_level, 0);
    check_eq("rst_raddr", raddr, 0);
    check_eq("rst_rptr", rptr_gray, 0);
    check_eq("rst_valid", rd_valid, 0);
    check_eq("rst_underflow", underflow, 0);
    check_eq("rst_count", fifo_read_count, 0);

    hw_rst_n    = 1'b1;
    read_enable = 1'b0;
    @(negedge rclk);
    check_eq("post_rst_rempty", rempty, 1);

    // 2: fill to 32, level appears 3 edges after the last pointer step
    for (int i = 1; i <= 32; i++) begin
      wbin = 6'(i);
      @(negedge rclk);
    end
    @(negedge rclk);
    check_eq("fill_level_2edges", rd_level, 31);
    @(negedge rclk);
    check_eq("fill_level_3edges", rd_level, 32);
    check_eq("fill_rempty", rempty, 0);
    check_eq("fill_aempty", rd_almost_empty, 0);

    // 2 + 5: drain 32, almost-empty rises on the read leaving 4
    for (int i = 0; i < 32; i++) begin
      read_enable = 1'b1;
      @(negedge rclk);
      check_eq("drain_valid", rd_valid, 1);
      check_eq("drain_data", rdata, exp_word(rd_idx));
      check_eq("drain_level", rd_level, 31 - i);
      check_eq("drain_rempty", rempty, (i == 31) ? 1 : 0);
      check_eq("drain_aempty", rd_almost_empty, (31 - i <= 4) ? 1 : 0);
      check_eq("drain_underflow", underflow, 0);
      rd_idx = rd_idx + 6'd1;
    end

    // 3: underflow while empty
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      check_eq("uf_pulse", underflow, 1);
      check_eq("uf_valid", rd_valid, 0);
      check_eq("uf_raddr", raddr, 0);
      check_eq("uf_rdata_hold", rdata, 32'hC0DE_001F);
    end
    read_enable = 1'b0;
    @(negedge rclk);
    check_eq("uf_clear", underflow, 0);
    check_eq("uf_rptr", rptr_gray, 6'b110000);

    // 4: 40 write/read pairs across the pointer wrap
    for (int k = 0; k < 40; k++) begin
      int t;
      logic [ADDR_W:0] nx;
      wbin = wbin + 6'd1;
      t = 0;
      do begin
        @(negedge rclk);
        t++;
      end while (rempty && t < 8);
      check_eq("wrap_not_empty", rempty, 0);
      check_eq("wrap_level1", rd_level, 1);
      read_enable = 1'b1;
      @(negedge rclk);
      read_enable = 1'b0;
      nx = rd_idx + 6'd1;
      check_eq("wrap_valid", rd_valid, 1);
      check_eq("wrap_data", rdata, exp_word(rd_idx));
      check_eq("wrap_rempty", rempty, 1);
      check_eq("wrap_level0", rd_level, 0);
      check_eq("wrap_rptr", rptr_gray, to_gray(nx));
      if (k == 31) check_eq("wrap_msb_back", rptr_gray[ADDR_W], 0);
      rd_idx = nx;
    end
    check_eq("count_72", fifo_read_count, CNT_EN ? 8 : 0);

    // 5: soft reset with pending entries and read_enable high
    push(3);
    wait_level(3);
    sw_rst      = 1'b1;
    read_enable = 1'b1;
    wbin        = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      check_eq("sw_valid", rd_valid, 0);
      check_eq("sw_raddr", raddr, 0);
      check_eq("sw_rptr", rptr_gray, 0);
      check_eq("sw_rempty", rempty, 1);
      check_eq("sw_aempty", rd_almost_empty, 1);
      check_eq("sw_underflow", underflow, 0);
      check_eq("sw_level", rd_level, 0);
      check_eq("sw_count", fifo_read_count, 0);
    end
    sw_rst      = 1'b0;
    read_enable = 1'b0;
    rd_idx      = '0;
    repeat (2) @(negedge rclk);
    check_eq("sw_post_rempty", rempty, 1);
    check_eq("sw_post_level", rd_level, 0);

    // 6: 70 accepted reads
    push(32);
    wait_level(32);
    pull(32);
    push(32);
    wait_level(32);
    pull(32);
    push(6);
    wait_level(6);
    pull(6);
    check_eq("cnt_rempty", rempty, 1);
    check_eq("count_70", fifo_read_count, CNT_EN ? 6 : 0);

    // aempty_value = 0 makes almost-empty follow empty
    aempty_value = 5'd0;
    @(negedge rclk);
    check_eq("ae0_empty", rd_almost_empty, 1);
    push(1);
    wait_level(1);
    check_eq("ae0_one", rd_almost_empty, 0);

    // async reset in the middle of a read
    read_enable = 1'b1;
    hw_rst_n    = 1'b0;
    wbin        = '0;
    #1;
    check_eq("hw_mid_rempty", rempty, 1);
    check_eq("hw_mid_level", rd_level, 0);
    check_eq("hw_mid_valid", rd_valid, 0);
    check_eq("hw_mid_raddr", raddr, 0);
    @(negedge rclk);
    hw_rst_n    = 1'b1;
    read_enable = 1'b0;
    repeat (2) @(negedge rclk);
    check_eq("hw_mid_post_rempty", rempty, 1);
    check_eq("hw_mid_post_count", fifo_read_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
